// File: rtl/ntt_pkg.sv
// Shared helpers for the NTT twiddle store: width helpers and address bit reversal.
package ntt_pkg;

  // Widest address the bit-reversal helper handles.
  localparam int BITREV_MAXW = 32;

  // Ceil(log2(v)) with a floor of 1, so single-entry stores still get a 1-bit address.
  function automatic int clog2_f1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // Bits needed to hold the values 0..v inclusive.
  function automatic int count_w(input int v);
    return clog2_f1(v + 1);
  endfunction

  // Reverse the low nbits of addr; bits at and above nbits come back as zero.
  function automatic logic [BITREV_MAXW-1:0] bitrev(input logic [BITREV_MAXW-1:0] addr,
                                                    input int nbits);
    logic [BITREV_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAXW; i++) begin
      if (i < nbits) r[i] = addr[5'(nbits - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/twiddle_rd_port.sv
// One registered read lane: optional bit-reversed remap, range check, and
// data/err/valid registers with one cycle of latency.
module twiddle_rd_port
  import ntt_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_bitrev,
  input  logic [AW-1:0] i_addr,
  output logic [AW-1:0] o_idx,
  input  logic [W-1:0]  i_mem_data,
  input  logic          i_mem_written,
  output logic [W-1:0]  o_data,
  output logic          o_valid,
  output logic          o_err
);

  logic [BITREV_MAXW-1:0] w_addr_ext;
  logic [BITREV_MAXW-1:0] w_addr_eff;
  logic                   w_oor;

  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_err;

  assign w_addr_ext = BITREV_MAXW'(i_addr);
  assign w_addr_eff = i_bitrev ? bitrev(w_addr_ext, AW) : w_addr_ext;
  assign w_oor      = (w_addr_eff >= BITREV_MAXW'(DEPTH));
  // Out-of-range requests look up entry 0 so the array is never indexed past its end;
  // the looked-up word is discarded in that case.
  assign o_idx      = w_oor ? '0 : w_addr_eff[AW-1:0];

  // Capture the response on a request; data and err hold when the lane is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= i_en;
      if (i_en) begin
        r_data <= w_oor ? '0 : i_mem_data;
        r_err  <= w_oor | ~i_mem_written;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_err   = r_err;

endmodule

// File: rtl/twiddle_mem_mp.sv
// Twiddle-factor store: streaming fill with auto-incrementing pointer, per-entry
// written tracking, soft clear, and NRD independent registered read lanes.
module twiddle_mem_mp
  import ntt_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int NRD   = 2,
  localparam int AW   = clog2_f1(DEPTH),
  localparam int CW   = count_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [W-1:0]      load_data,
  input  logic              rd_bitrev,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*W-1:0]  rd_data,
  output logic [NRD-1:0]    rd_valid,
  output logic [NRD-1:0]    rd_err,
  output logic [CW-1:0]     count,
  output logic              full
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] r_written;
  // The write pointer always equals the fill count, so one register serves both.
  logic [CW-1:0]    r_count;

  logic             w_full;
  logic             w_accept;
  logic [AW-1:0]    w_wr_idx;

  assign w_full     = (r_count == CW'(DEPTH));
  assign load_ready = ~w_full;
  assign w_accept   = load_valid & ~w_full & ~clear;
  assign w_wr_idx   = r_count[AW-1:0];

  // Fill control: reset and clear empty the store; an accepted word advances the pointer.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count   <= '0;
      r_written <= '0;
    end else if (w_accept) begin
      r_count             <= r_count + CW'(1);
      r_written[w_wr_idx] <= 1'b1;
    end
  end

  // Memory array: written only on an accepted load, never reset.
  always_ff @(posedge clk) begin
    if (w_accept && !rst) r_mem[w_wr_idx] <= load_data;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_idx;
    logic [W-1:0]  w_q;
    logic          w_vld;
    logic          w_err;

    twiddle_rd_port #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_port (
      .clk           (clk),
      .rst           (rst),
      .i_en          (rd_en[g]),
      .i_bitrev      (rd_bitrev),
      .i_addr        (rd_addr[g*AW +: AW]),
      .o_idx         (w_idx),
      .i_mem_data    (r_mem[w_idx]),
      .i_mem_written (r_written[w_idx]),
      .o_data        (w_q),
      .o_valid       (w_vld),
      .o_err         (w_err)
    );

    assign rd_data[g*W +: W] = w_q;
    assign rd_valid[g]       = w_vld;
    assign rd_err[g]         = w_err;
  end

  assign count = r_count;
  assign full  = w_full;

endmodule

// File: tb/tb_twiddle_mem_mp.sv
// Scoreboard bench for twiddle_mem_mp: a DEPTH=8 and a DEPTH=6 instance share one clock.
module tb_twiddle_mem_mp;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=8 instance
  logic        rst8, clr8, lv8, lr8, br8, full8;
  logic [31:0] ld8;
  logic [1:0]  en8, rv8, re8;
  logic [5:0]  ad8;
  logic [63:0] rd8;
  logic [3:0]  cnt8;

  // DEPTH=6 instance
  logic        rst6, clr6, lv6, lr6, br6, full6;
  logic [31:0] ld6;
  logic [1:0]  en6, rv6, re6;
  logic [5:0]  ad6;
  logic [63:0] rd6;
  logic [2:0]  cnt6;

  twiddle_mem_mp #(.W(32), .DEPTH(8), .NRD(2)) dut8 (
    .clk(clk), .rst(rst8), .clear(clr8), .load_valid(lv8), .load_ready(lr8),
    .load_data(ld8), .rd_bitrev(br8), .rd_en(en8), .rd_addr(ad8), .rd_data(rd8),
    .rd_valid(rv8), .rd_err(re8), .count(cnt8), .full(full8)
  );

  twiddle_mem_mp #(.W(32), .DEPTH(6), .NRD(2)) dut6 (
    .clk(clk), .rst(rst6), .clear(clr6), .load_valid(lv6), .load_ready(lr6),
    .load_data(ld6), .rd_bitrev(br6), .rd_en(en6), .rd_addr(ad6), .rd_data(rd6),
    .rd_valid(rv6), .rd_err(re6), .count(cnt6), .full(full6)
  );

  int checks = 0;
  int errors = 0;

  exp_t q80[$];
  exp_t q81[$];
  exp_t q60[$];
  exp_t q61[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int which, input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    case (which)
      0: q80.push_back(x);
      1: q81.push_back(x);
      2: q60.push_back(x);
      default: q61.push_back(x);
    endcase
  endtask

  // Pop the oldest expectation for a lane and compare it with what the lane presents.
  task automatic sb_check(input string nm, input int which, input logic [31:0] d, input logic e);
    exp_t x;
    int   sz;
    case (which)
      0: sz = q80.size();
      1: sz = q81.size();
      2: sz = q60.size();
      default: sz = q61.size();
    endcase
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected rd_valid data 0x%0h err %0b", nm, d, e);
    end else begin
      case (which)
        0: x = q80.pop_front();
        1: x = q81.pop_front();
        2: x = q60.pop_front();
        default: x = q61.pop_front();
      endcase
      chk({nm, "_data"}, 64'(d), 64'(x.data));
      chk({nm, "_err"},  64'(e), 64'(x.err));
    end
  endtask

  // Monitor: compare every valid read response against the scoreboard.
  always @(negedge clk) begin
    if (rv8[0] === 1'b1) sb_check("d8_p0", 0, rd8[31:0],  re8[0]);
    if (rv8[1] === 1'b1) sb_check("d8_p1", 1, rd8[63:32], re8[1]);
    if (rv6[0] === 1'b1) sb_check("d6_p0", 2, rd6[31:0],  re6[0]);
    if (rv6[1] === 1'b1) sb_check("d6_p1", 3, rd6[63:32], re6[1]);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one read cycle on the DEPTH=8 instance and record what each lane must return.
  task automatic rd8_cyc(input logic [1:0] en, input logic br, input logic [2:0] a0,
                         input logic [2:0] a1, input logic [31:0] d0, input logic e0,
                         input logic [31:0] d1, input logic e1);
    en8 = en;
    br8 = br;
    ad8 = {a1, a0};
    if (en[0]) push(0, d0, e0);
    if (en[1]) push(1, d1, e1);
    tick;
    en8 = 2'b00;
    br8 = 1'b0;
  endtask

  task automatic rd6_cyc(input logic [1:0] en, input logic br, input logic [2:0] a0,
                         input logic [2:0] a1, input logic [31:0] d0, input logic e0,
                         input logic [31:0] d1, input logic e1);
    en6 = en;
    br6 = br;
    ad6 = {a1, a0};
    if (en[0]) push(2, d0, e0);
    if (en[1]) push(3, d1, e1);
    tick;
    en6 = 2'b00;
    br6 = 1'b0;
  endtask

  initial begin
    rst8 = 1'b1; clr8 = 1'b0; lv8 = 1'b0; ld8 = '0; br8 = 1'b0; en8 = '0; ad8 = '0;
    rst6 = 1'b1; clr6 = 1'b0; lv6 = 1'b0; ld6 = '0; br6 = 1'b0; en6 = '0; ad6 = '0;
    tick;
    tick;
    rst8 = 1'b0;

    // Reset state
    chk("rst_count", 64'(cnt8), 64'd0);
    chk("rst_full", 64'(full8), 64'd0);
    chk("rst_ready", 64'(lr8), 64'd1);
    chk("rst_valid", 64'(rv8), 64'd0);
    chk("rst_data", rd8, 64'd0);
    chk("rst_err", 64'(re8), 64'd0);

    // Fill with 0x10..0x17 holding load_valid high
    lv8 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ld8 = 32'h10 + 32'(k);
      tick;
      chk($sformatf("fill_count_%0d", k), 64'(cnt8), 64'(k + 1));
    end
    chk("fill_full", 64'(full8), 64'd1);
    chk("fill_ready", 64'(lr8), 64'd0);
    ld8 = 32'h99;
    tick;
    chk("ninth_stall", 64'(cnt8), 64'd8);
    lv8 = 1'b0;

    // Two-port read
    rd8_cyc(2'b11, 1'b0, 3'd3, 3'd5, 32'h13, 1'b0, 32'h15, 1'b0);
    chk("two_port_data", rd8, {32'h15, 32'h13});
    chk("two_port_valid", 64'(rv8), 64'h3);

    // Bit reversal: 1 -> 4, 3 -> 6
    rd8_cyc(2'b11, 1'b1, 3'd1, 3'd3, 32'h14, 1'b0, 32'h16, 1'b0);
    // Both lanes on the same address
    rd8_cyc(2'b11, 1'b0, 3'd7, 3'd7, 32'h17, 1'b0, 32'h17, 1'b0);

    // Clear with simultaneous load at count 8, then again at count 0
    clr8 = 1'b1; lv8 = 1'b1; ld8 = 32'hAA;
    tick;
    chk("clr_count", 64'(cnt8), 64'd0);
    chk("clr_full", 64'(full8), 64'd0);
    chk("clr_ready", 64'(lr8), 64'd1);
    ld8 = 32'hAB;
    tick;
    chk("clr_load_count", 64'(cnt8), 64'd0);
    clr8 = 1'b0; lv8 = 1'b0;
    rd8_cyc(2'b01, 1'b0, 3'd0, 3'd0, 32'h10, 1'b1, 32'h0, 1'b0);

    // Partial fill of three words
    lv8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ld8 = 32'h20 + 32'(k);
      tick;
    end
    lv8 = 1'b0;
    chk("partial_count", 64'(cnt8), 64'd3);
    rd8_cyc(2'b01, 1'b0, 3'd6, 3'd0, 32'h16, 1'b1, 32'h0, 1'b0);

    // Read-during-write on entry 3: old data and old flag, then the new word
    lv8 = 1'b1; ld8 = 32'h23;
    rd8_cyc(2'b01, 1'b0, 3'd3, 3'd0, 32'h13, 1'b1, 32'h0, 1'b0);
    lv8 = 1'b0;
    chk("rdw_count", 64'(cnt8), 64'd4);
    rd8_cyc(2'b11, 1'b0, 3'd3, 3'd0, 32'h23, 1'b0, 32'h20, 1'b0);

    // Idle lanes drop valid and hold data/err
    tick;
    chk("idle_valid", 64'(rv8), 64'd0);
    chk("idle_hold", rd8, {32'h20, 32'h23});
    chk("idle_err", 64'(re8), 64'd0);

    // DEPTH=6 instance
    rst6 = 1'b0;
    lv6 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ld6 = 32'h30 + 32'(k);
      tick;
    end
    lv6 = 1'b0;
    chk("d6_count", 64'(cnt6), 64'd6);
    chk("d6_full", 64'(full6), 64'd1);
    chk("d6_ready", 64'(lr6), 64'd0);
    // bitrev 3 -> 6 (out of range), 4 -> 1
    rd6_cyc(2'b11, 1'b1, 3'd3, 3'd4, 32'h0, 1'b1, 32'h31, 1'b0);
    // plain 7 out of range, 5 last entry
    rd6_cyc(2'b11, 1'b0, 3'd7, 3'd5, 32'h0, 1'b1, 32'h35, 1'b0);

    // rst mid-load
    rst6 = 1'b1;
    tick;
    rst6 = 1'b0;
    lv6 = 1'b1;
    ld6 = 32'h40;
    tick;
    ld6 = 32'h41;
    tick;
    chk("d6_mid_count", 64'(cnt6), 64'd2);
    rst6 = 1'b1; ld6 = 32'h42; en6 = 2'b01; ad6 = 6'd0;
    tick;
    rst6 = 1'b0; lv6 = 1'b0; en6 = 2'b00;
    chk("d6_rst_count", 64'(cnt6), 64'd0);
    chk("d6_rst_valid", 64'(rv6), 64'd0);
    chk("d6_rst_data", rd6, 64'd0);
    lv6 = 1'b1; ld6 = 32'h50;
    tick;
    lv6 = 1'b0;
    chk("d6_reload_count", 64'(cnt6), 64'd1);
    rd6_cyc(2'b11, 1'b0, 3'd0, 3'd1, 32'h50, 1'b0, 32'h41, 1'b1);
    rd6_cyc(2'b01, 1'b0, 3'd2, 3'd0, 32'h32, 1'b1, 32'h0, 1'b0);

    tick;
    tick;
    chk("sb_drain", 64'(q80.size() + q81.size() + q60.size() + q61.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
